// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter slice.
//   - ADDR_W / DATA_W : external 256K x 8 SRAM geometry
//   - arb_state_t     : arbiter state (IDLE, CPU_ACC, AUX_ACC)
package sram_arb_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    AUX_ACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the CPU port, the auxiliary requester port and the SRAM pad
// signals around sram_arbiter.
//   slave  : arbiter view (requests in, completions and SRAM strobes out)
//   master : environment view (requesters and the SRAM device)
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  // CPU port: single-cycle request pulse, single-cycle done pulse
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;

  // Auxiliary port: level request held until ack
  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_ack;

  // SRAM pads (strobes active-low)
  logic              ram_cs_b;
  logic              ram_oe_b;
  logic              ram_we_b;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_dout_en;
  logic [DATA_W-1:0] ram_din;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_rdata, aux_ack,
    output ram_cs_b, ram_oe_b, ram_we_b, ram_addr, ram_dout, ram_dout_en,
    input  ram_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_rdata, aux_ack,
    input  ram_cs_b, ram_oe_b, ram_we_b, ram_addr, ram_dout, ram_dout_en,
    output ram_din
  );

endinterface

// File: rtl/sram_access_seq.sv
// Strobe sequencer for one SRAM access slot of ACCESS_CYCLES clocks.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a slot (ignored while a slot is running)
//   we           : slot is a write
//   protect      : write slot that must not reach the SRAM
//   last         : high during the final clock of the slot (cnt == 0)
//   ram_cs_b, ram_oe_b, ram_we_b, ram_dout_en : registered pad controls
// A down-counter cnt runs ACCESS_CYCLES-1 .. 0; ram_we_b is low only for
// cnt in [ACCESS_CYCLES-2 .. 1], giving one clock of setup and one of hold.
module sram_access_seq #(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic we,
  input  logic protect,
  output logic last,
  output logic ram_cs_b,
  output logic ram_oe_b,
  output logic ram_we_b,
  output logic ram_dout_en
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             active;
  logic             wr_live;   // write that actually drives the SRAM

  assign last = active && (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active      <= 1'b0;
      cnt         <= '0;
      wr_live     <= 1'b0;
      ram_cs_b    <= 1'b1;
      ram_oe_b    <= 1'b1;
      ram_we_b    <= 1'b1;
      ram_dout_en <= 1'b0;
    end else if (start && !active) begin
      active      <= 1'b1;
      cnt         <= CNT_W'(ACCESS_CYCLES - 1);
      wr_live     <= we && !protect;
      ram_cs_b    <= 1'b0;
      ram_oe_b    <= we;
      ram_we_b    <= 1'b1;               // setup clock
      ram_dout_en <= we && !protect;
    end else if (active) begin
      if (cnt == '0) begin
        active      <= 1'b0;
        ram_cs_b    <= 1'b1;
        ram_oe_b    <= 1'b1;
        ram_we_b    <= 1'b1;
        ram_dout_en <= 1'b0;
      end else begin
        cnt      <= cnt - CNT_W'(1);
        // next cnt lies in [1 .. ACCESS_CYCLES-2] exactly when cnt >= 2
        ram_we_b <= !(wr_live && (cnt >= CNT_W'(2)));
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter sharing the external 256K x 8 asynchronous SRAM between the 6502
// CPU port and an auxiliary requester (bootstrap loader / DMA).
//   clk     : 100 MHz clock
//   reset_n : asynchronous active-low reset
//   bus     : sram_arbiter_if.slave (CPU port, aux port, SRAM pads)
// The CPU has strict, non-preemptive priority. A CPU request is captured
// into cpu_pending (last request wins) until it is granted.
// Optional feature: define SRAM_WRITE_PROTECT_EN to block CPU writes in
// [WP_BASE .. WP_LIMIT]; such writes still run a full slot and pulse
// cpu_done but never assert ram_we_b or ram_dout_en. Aux writes are never
// blocked.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int              ACCESS_CYCLES = 4,
  parameter logic [ADDR_W-1:0] WP_BASE     = 18'h0C000,
  parameter logic [ADDR_W-1:0] WP_LIMIT    = 18'h0FFFF
) (
  input  logic           clk,
  input  logic           reset_n,
  sram_arbiter_if.slave  bus
);

  if (ACCESS_CYCLES < 3) begin : g_bad_cycles
    $error("sram_arbiter: ACCESS_CYCLES must be at least 3");
  end
  if (WP_BASE > WP_LIMIT) begin : g_bad_wp
    $error("sram_arbiter: WP_BASE must not exceed WP_LIMIT");
  end

  arb_state_t        state;
  logic              cpu_pending;
  logic              cpu_we_q;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic [DATA_W-1:0] cpu_wdata_q;
  logic              acc_we;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              grant_cpu;
  logic              grant_aux;
  logic              cpu_prot;
  logic              seq_last;

  // A request arriving in the grant cycle itself is used directly, so a
  // newer request always overrides the captured one.
  assign sel_we    = bus.cpu_req ? bus.cpu_we    : cpu_we_q;
  assign sel_addr  = bus.cpu_req ? bus.cpu_addr  : cpu_addr_q;
  assign sel_wdata = bus.cpu_req ? bus.cpu_wdata : cpu_wdata_q;

  assign grant_cpu = (state == IDLE) && (bus.cpu_req || cpu_pending);
  // aux_req is still high in its own ack cycle; it must not regrant then.
  assign grant_aux = (state == IDLE) && !grant_cpu && bus.aux_req && !bus.aux_ack;

`ifdef SRAM_WRITE_PROTECT_EN
  assign cpu_prot = sel_we && (sel_addr >= WP_BASE) && (sel_addr <= WP_LIMIT);
`else
  assign cpu_prot = 1'b0;
`endif

  sram_access_seq #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_seq (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (grant_cpu || grant_aux),
    .we          (grant_cpu ? sel_we : bus.aux_we),
    .protect     (grant_cpu && cpu_prot),
    .last        (seq_last),
    .ram_cs_b    (bus.ram_cs_b),
    .ram_oe_b    (bus.ram_oe_b),
    .ram_we_b    (bus.ram_we_b),
    .ram_dout_en (bus.ram_dout_en)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cpu_pending   <= 1'b0;
      cpu_we_q      <= 1'b0;
      cpu_addr_q    <= '0;
      cpu_wdata_q   <= '0;
      acc_we        <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_dout  <= '0;
      bus.cpu_rdata <= '0;
      bus.aux_rdata <= '0;
      bus.cpu_done  <= 1'b0;
      bus.aux_ack   <= 1'b0;
    end else begin
      bus.cpu_done <= 1'b0;
      bus.aux_ack  <= 1'b0;

      if (bus.cpu_req) begin
        cpu_we_q    <= bus.cpu_we;
        cpu_addr_q  <= bus.cpu_addr;
        cpu_wdata_q <= bus.cpu_wdata;
      end
      if (grant_cpu) begin
        cpu_pending <= 1'b0;
      end else if (bus.cpu_req) begin
        cpu_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state        <= CPU_ACC;
            acc_we       <= sel_we;
            bus.ram_addr <= sel_addr;
            bus.ram_dout <= sel_wdata;
          end else if (grant_aux) begin
            state        <= AUX_ACC;
            acc_we       <= bus.aux_we;
            bus.ram_addr <= bus.aux_addr;
            bus.ram_dout <= bus.aux_wdata;
          end
        end
        CPU_ACC: begin
          if (seq_last) begin
            state        <= IDLE;
            bus.cpu_done <= 1'b1;
            if (!acc_we) bus.cpu_rdata <= bus.ram_din;
          end
        end
        AUX_ACC: begin
          if (seq_last) begin
            state       <= IDLE;
            bus.aux_ack <= 1'b1;
            if (!acc_we) bus.aux_rdata <= bus.ram_din;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM device model, reference memory, scoreboard
// queues filled at issue time and drained by an independent monitor.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int              AC  = 4;
  localparam logic [ADDR_W-1:0] WPB = 18'h0C000;
  localparam logic [ADDR_W-1:0] WPL = 18'h0FFFF;
`ifdef SRAM_WRITE_PROTECT_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if bus();

  sram_arbiter #(.ACCESS_CYCLES(AC), .WP_BASE(WPB), .WP_LIMIT(WPL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Asynchronous SRAM device
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (!bus.ram_cs_b && !bus.ram_we_b) mem[bus.ram_addr] <= bus.ram_dout;
  assign bus.ram_din = (!bus.ram_cs_b && !bus.ram_oe_b) ? mem[bus.ram_addr] : 8'h00;

  // Reference model: expected memory contents, updated in issue order
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                issue;
    int                lmin;
    int                lmax;
  } exp_t;
  exp_t cpu_q[$];
  exp_t aux_q[$];

  function automatic bit wp_hit(logic [ADDR_W-1:0] a);
    return WP_ON && (a >= WPB) && (a <= WPL);
  endfunction

  task automatic chk(string name, bit ok, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int                run, oe_n, we_n, en_n, n_acc, n_we_low, n_cpu_done, lat;
  int                cpu_done_cyc, aux_ack_cyc;
  logic [ADDR_W-1:0] a0;
  logic [DATA_W-1:0] d0, last_cpu_read;
  bit                stable, pok;
  logic [23:0]       pat;
  exp_t              ce, ae;

  initial begin
    run = 0; oe_n = 0; we_n = 0; en_n = 0; n_acc = 0; n_we_low = 0;
    n_cpu_done = 0; cpu_done_cyc = 0; aux_ack_cyc = 0; last_cpu_read = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run = 0; oe_n = 0; we_n = 0; en_n = 0; last_cpu_read = 8'h00;
      end else begin
        if (!bus.ram_cs_b) begin
          run++;
          if (run == 1) begin
            a0 = bus.ram_addr; d0 = bus.ram_dout; stable = 1'b1;
          end else if (bus.ram_addr != a0 || bus.ram_dout != d0) begin
            stable = 1'b0;
          end
          if (!bus.ram_oe_b) oe_n++;
          if (!bus.ram_we_b) begin we_n++; n_we_low++; end
          if (bus.ram_dout_en) en_n++;
        end else if (run != 0) begin
          n_acc++;
          chk("slot_length", run == AC, run, AC);
          chk("addr_data_stable", stable, stable, 1);
          chk("gap_strobes_idle", bus.ram_oe_b && bus.ram_we_b && !bus.ram_dout_en,
              {bus.ram_oe_b, bus.ram_we_b, bus.ram_dout_en}, 3'b110);
          pat = {8'(oe_n), 8'(we_n), 8'(en_n)};
          pok = (pat == {8'(AC), 16'd0}) || (pat == {8'd0, 8'(AC-2), 8'(AC)}) ||
                (pat == 24'd0 && wp_hit(a0));
          chk("strobe_pattern", pok, pat,
              (oe_n != 0) ? {8'(AC), 16'd0} : {8'd0, 8'(AC-2), 8'(AC)});
          run = 0; oe_n = 0; we_n = 0; en_n = 0;
        end
        if (bus.cpu_done) begin
          n_cpu_done++;
          cpu_done_cyc = cyc;
          if (cpu_q.size() == 0) chk("cpu_done_unexpected", 1'b0, 1, 0);
          else begin
            ce = cpu_q.pop_front();
            lat = cyc - ce.issue;
            chk("cpu_latency", lat >= ce.lmin && lat <= ce.lmax, lat, ce.lmax);
            if (!ce.we) begin
              chk("cpu_rdata", bus.cpu_rdata == ce.data, bus.cpu_rdata, ce.data);
              last_cpu_read = ce.data;
            end else begin
              chk("cpu_rdata_hold", bus.cpu_rdata == last_cpu_read, bus.cpu_rdata, last_cpu_read);
            end
          end
        end
        if (bus.aux_ack) begin
          aux_ack_cyc = cyc;
          if (aux_q.size() == 0) chk("aux_ack_unexpected", 1'b0, 1, 0);
          else begin
            ae = aux_q.pop_front();
            if (!ae.we) chk("aux_rdata", bus.aux_rdata == ae.data, bus.aux_rdata, ae.data);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cpu_issue(bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                           int lmin = AC + 1, int lmax = 2 * AC + 2);
    exp_t e;
    @(negedge clk);
    e.we = we; e.addr = a; e.issue = cyc; e.lmin = lmin; e.lmax = lmax;
    if (we) begin
      e.data = d;
      if (!wp_hit(a)) ref_mem[a] = d;
    end else begin
      e.data = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    end
    cpu_q.push_back(e);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_wdata = 8'($urandom);
  endtask

  task automatic cpu_wait();
    for (int i = 0; i < 40 && cpu_q.size() != 0; i++) @(negedge clk);
    if (cpu_q.size() != 0) begin
      chk("cpu_timeout", 1'b0, cpu_q.size(), 0);
      cpu_q.delete();
    end
  endtask

  task automatic cpu_op(bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                        int lmin = AC + 1, int lmax = 2 * AC + 2);
    cpu_issue(we, a, d, lmin, lmax);
    cpu_wait();
    repeat (6) @(negedge clk);
  endtask

  task automatic aux_op(bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    exp_t e;
    bit   got;
    @(negedge clk);
    e.we = we; e.addr = a; e.issue = cyc; e.lmin = 0; e.lmax = 0;
    if (we) begin e.data = d; ref_mem[a] = d; end
    else e.data = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    aux_q.push_back(e);
    bus.aux_req = 1'b1; bus.aux_we = we; bus.aux_addr = a; bus.aux_wdata = d;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      got = bus.aux_ack;
    end
    bus.aux_req = 1'b0;
    if (!got) begin
      chk("aux_timeout", 1'b0, 0, 1);
      aux_q.delete();
    end
  endtask

  logic [ADDR_W-1:0] cpool [16];
  logic [ADDR_W-1:0] apool [16];
  int base_done, base_acc, base_we;

  initial begin
    reset_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.aux_req = 1'b0; bus.aux_we = 1'b0; bus.aux_addr = '0; bus.aux_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      cpool[i] = (i < 4) ? ADDR_W'(18'h0C400 + i * 101) : ADDR_W'(18'h02000 + i * 37);
      apool[i] = ADDR_W'(18'h20000 + i * 1031);
    end

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_strobes", {bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b, bus.ram_dout_en} == 4'b1110,
        {bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b, bus.ram_dout_en}, 4'b1110);
    chk("rst_ram_addr", bus.ram_addr == '0, bus.ram_addr, 0);
    chk("rst_ram_dout", bus.ram_dout == '0, bus.ram_dout, 0);
    chk("rst_rdata", {bus.cpu_rdata, bus.aux_rdata} == 16'h0, {bus.cpu_rdata, bus.aux_rdata}, 0);
    chk("rst_pulses", {bus.cpu_done, bus.aux_ack} == 2'b00, {bus.cpu_done, bus.aux_ack}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // idle CPU read, exact latency
    aux_op(1'b1, 18'h01234, 8'hA5);
    cpu_op(1'b0, 18'h01234, 8'h00, AC + 1, AC + 1);

    // CPU write and readback
    base_we = n_we_low;
    cpu_op(1'b1, 18'h00200, 8'h3C, AC + 1, AC + 1);
    chk("cpu_write_we_cycles", n_we_low - base_we == AC - 2, n_we_low - base_we, AC - 2);
    cpu_op(1'b0, 18'h00200, 8'h00, AC + 1, AC + 1);

    // collision: CPU request in the 2nd cycle of an aux write
    fork
      aux_op(1'b1, 18'h10000, 8'h11);
      begin
        repeat (2) @(negedge clk);
        cpu_issue(1'b0, 18'h01234, 8'h00);
      end
    join
    cpu_wait();
    chk("collision_order", cpu_done_cyc - aux_ack_cyc == AC + 1, cpu_done_cyc - aux_ack_cyc, AC + 1);
    repeat (6) @(negedge clk);
    aux_op(1'b0, 18'h10000, 8'h00);

    // write protection window
    aux_op(1'b1, 18'h0C000, 8'h5A);
    base_we = n_we_low;
    cpu_op(1'b1, 18'h0C000, 8'hFF);
    chk("wp_cpu_we_cycles", n_we_low - base_we == (WP_ON ? 0 : AC - 2),
        n_we_low - base_we, WP_ON ? 0 : AC - 2);
    cpu_op(1'b0, 18'h0C000, 8'h00);
    aux_op(1'b1, 18'h0C000, 8'hFF);
    cpu_op(1'b0, 18'h0C000, 8'h00);

    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      aux_op(1'b1, cpool[i], 8'($urandom));
      aux_op(1'b1, apool[i], 8'($urandom));
    end
    fork
      for (int k = 0; k < 40; k++) begin
        cpu_issue(1'($urandom), cpool[$urandom_range(0, 15)], 8'($urandom));
        cpu_wait();
        repeat ($urandom_range(6, 12)) @(negedge clk);
      end
      for (int k = 0; k < 40; k++) begin
        aux_op(1'($urandom), apool[$urandom_range(0, 15)], 8'($urandom));
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    join
    repeat (4) @(negedge clk);

    // reset in the 3rd cycle of a CPU write, with a newer request pending
    aux_op(1'b1, 18'h00300, 8'h77);
    repeat (6) @(negedge clk);
    base_done = n_cpu_done;
    base_acc  = n_acc;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 18'h00300; bus.cpu_wdata = 8'hAA;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_strobes_async", {bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b, bus.ram_dout_en} == 4'b1110,
        {bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b, bus.ram_dout_en}, 4'b1110);
    ref_mem.delete(18'h00300);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("reset_ram_addr", bus.ram_addr == '0, bus.ram_addr, 0);
    repeat (15) @(negedge clk);
    chk("reset_no_done", n_cpu_done == base_done, n_cpu_done - base_done, 0);
    chk("reset_pending_dropped", n_acc == base_acc, n_acc - base_acc, 0);

    // normal service resumes after reset
    cpu_op(1'b0, 18'h01234, 8'h00, AC + 1, AC + 1);
    chk("queues_drained", cpu_q.size() + aux_q.size() == 0, cpu_q.size() + aux_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external 256K x 8 asynchronous SRAM between the 6502 CPU port and an auxiliary requester (bootstrap loader / future DMA), replacing the fixed mux in front of the SRAM pins. Runs on the 100 MHz clock, sequences each access with a fixed strobe pattern, gives the CPU strict priority, and optionally write-protects the ROM image region from CPU stores.

## Interface
- ACCESS_CYCLES, 4: clocks per SRAM access; must be ≥ 3.
- WP_BASE, 18'h0C000: first write-protected address.
- WP_LIMIT, 18'h0FFFF: last write-protected address, inclusive.

- clk  in  1  100 MHz clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  single-cycle request pulse.
- cpu_we  in  1  1 = write; sampled with cpu_req.
- cpu_addr  in  18  sampled with cpu_req.
- cpu_wdata  in  8  sampled with cpu_req.
- cpu_rdata  out  8  read data; valid while cpu_done is high and held until the next CPU read completes.
- cpu_done  out  1  single-cycle completion pulse.
- aux_req  in  1  level request; held until aux_ack.
- aux_we, aux_addr[17:0], aux_wdata[7:0]  in  stable while aux_req is high.
- aux_rdata  out  8  valid while aux_ack is high.
- aux_ack  out  1  single-cycle completion pulse.
- ram_cs_b, ram_oe_b, ram_we_b  out  1  SRAM strobes, active-low.
- ram_addr  out  18  SRAM address.
- ram_dout  out  8  write data.
- ram_dout_en  out  1  pad output enable.
- ram_din  in  8  pad input data.

## Operation
- Reset values: all strobes 1; ram_dout_en 0; ram_addr 0; ram_dout 0; cpu_rdata 0; aux_rdata 0; cpu_done 0; aux_ack 0; state IDLE; cpu_pending 0.
- The block captures cpu_req into cpu_pending together with its we, address and wdata.
  - A second cpu_req before the first is granted overwrites the captured request (last wins).
  - The CPU guarantees a spacing of ≥ 2*ACCESS_CYCLES+2 clocks between requests.
- State machine: IDLE, CPU_ACC, AUX_ACC, with a down-counter cnt.
  - In IDLE, if cpu_req or cpu_pending is high: go to CPU_ACC. Else if aux_req is high: go to AUX_ACC. Else stay in IDLE.
  - On entry to an access state, cnt is loaded with ACCESS_CYCLES-1.
  - The access state ends when cnt reaches 0; the block then returns to IDLE.
- CPU priority is non-preemptive. A CPU request arriving during AUX_ACC is served immediately after that access ends, ahead of a still-asserted aux_req.
- Worst-case CPU latency from request to cpu_done: 2*ACCESS_CYCLES+2.
- Aux starvation is accepted; the CPU duty cycle is far below 50 %.
- Read access:
  - ram_cs_b and ram_oe_b are low for all ACCESS_CYCLES clocks.
  - ram_din is registered at the edge that ends the last cycle.
- Write access:
  - ram_cs_b is low for all cycles.
  - ram_dout_en is high for all cycles.
  - ram_we_b is low only while cnt is in [ACCESS_CYCLES-2 .. 1], so there is one clock of setup and one of hold.
- ram_addr and ram_dout are registered and change only on entry to an access state.

## Timing
- Idle grant: cpu_req high in cycle N, access occupies cycles N+1 .. N+ACCESS_CYCLES, and cpu_done is high in cycle N+ACCESS_CYCLES+1.
- Back-to-back accesses: the IDLE cycle carrying done/ack is also the next grant cycle. The minimum bus gap is 1 clock with all strobes high.
- aux_ack timing matches cpu_done timing. The requester must drop aux_req in the cycle after aux_ack, otherwise a new access is issued.
- Asserting reset_n low mid-access:
  - strobes go inactive and ram_dout_en goes to 0 immediately (asynchronously);
  - the pending request is discarded;
  - no done or ack pulse is produced.

## Configuration
- SRAM_WRITE_PROTECT_EN defined: a CPU write with WP_BASE ≤ addr ≤ WP_LIMIT runs a full access slot but keeps ram_we_b = 1 and ram_dout_en = 0. cpu_done still pulses. Aux writes are never protected.
- SRAM_WRITE_PROTECT_EN undefined: all writes reach the SRAM, and the comparator logic is absent.

## Structure
- Package sram_arb_pkg holds:
  - the state enum (IDLE, CPU_ACC, AUX_ACC);
  - the address width (18) and data width (8) constants.
- Sub-module sram_access_seq: given start, we and protect, it drives cnt and the strobe/enable pattern and produces a last pulse. The arbiter instantiates it once.

## Test plan
- Idle CPU read: preload 18'h01234 = 8'hA5, pulse cpu_req with cpu_we = 0 → cpu_done 5 clocks later, cpu_rdata = 8'hA5, ram_oe_b low for exactly 4 clocks.
- CPU write: write 8'h3C to 18'h00200 → ram_we_b low for exactly 2 clocks, data stable one clock either side; readback returns 8'h3C.
- Collision: aux write of 8'h11 to 18'h10000 in progress, cpu_req in its 2nd cycle → aux_ack first, CPU access starts one clock after aux_ack, cpu_done ≤ 10 clocks after cpu_req.
- Protection (macro defined): CPU writes 8'hFF to 18'h0C000 → no ram_we_b low, cpu_done pulses, memory unchanged. Same write via aux → memory = 8'hFF. Macro undefined → CPU write lands.
- Reset mid-write: assert reset_n low during the 3rd cycle of a write → strobes high in the same cycle, no cpu_done, cpu_pending clear after release.
